// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one latched character per accepted write into
// an 11-bit asynchronous frame (start, 7 data, bit8, bit9, stop), LSB first.
module uart_tx_engine #(
  parameter int FRAME_BITS = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] baud_div,
  input  logic        load,
  input  logic [7:0]  din,
  input  logic        eight,
  input  logic        pen,
  input  logic        ohel,
  output logic        tx,
  output logic        txrdy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [15:0]             baud_cnt_q, baud_cnt_d;
  logic [15:0]             div_q, div_d;

  logic accept;
  logic baud_tc;
  logic par7;
  logic par8;
  logic bit8;
  logic bit9;

  assign accept  = load && (state_q == IDLE);
  assign baud_tc = (baud_cnt_q == (div_q - 16'd1));

  // Parity sense: ohel=0 even (XOR of data), ohel=1 odd (XNOR of data).
  assign par7 = (^din[6:0]) ^ ohel;
  assign par8 = (^din[7:0]) ^ ohel;
  assign bit8 = eight ? din[7] : (pen ? par7 : 1'b1);
  assign bit9 = (eight && pen) ? par8 : 1'b1;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    div_d      = div_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = SHIFT;
          shift_d    = {1'b1, bit9, bit8, din[6:0], 1'b0};
          bit_cnt_d  = 4'd0;
          baud_cnt_d = 16'd0;
          div_d      = (baud_div == 16'd0) ? 16'd1 : baud_div;
        end
      end
      SHIFT: begin
        if (baud_tc) begin
          baud_cnt_d = 16'd0;
          shift_d    = {1'b1, shift_q[FRAME_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '1;
      bit_cnt_q  <= 4'd0;
      baud_cnt_q <= 16'd0;
      div_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
    end
  end

  // tx comes straight from the shift register flop, so the line never glitches.
  assign tx    = shift_q[0];
  assign txrdy = (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed frames plus randomized frames
// checked cycle by cycle against a frame/bit-time reference model.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic        load;
  logic [7:0]  din;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic        tx;
  logic        txrdy;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_engine dut (
    .clk      (clk),
    .reset    (reset),
    .baud_div (baud_div),
    .load     (load),
    .din      (din),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .tx       (tx),
    .txrdy    (txrdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  // Frame as the line should carry it, bit0 first.
  function automatic logic [10:0] ref_frame(input logic [7:0] d, input logic e,
                                            input logic p, input logic o);
    logic [10:0] f;
    logic        p7;
    logic        p8;
    p7 = (($countones(d[6:0]) % 2) == 1) ^ o;
    p8 = (($countones(d) % 2) == 1) ^ o;
    f[0] = 1'b0;
    for (int i = 1; i <= 7; i++) f[i] = d[i-1];
    if (e)      f[8] = d[7];
    else if (p) f[8] = p7;
    else        f[8] = 1'b1;
    f[9]  = (e && p) ? p8 : 1'b1;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_tx", tx, 1'b1);
      check("idle_txrdy", txrdy, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  // Called #1 after a clock edge. intr_at: cycle at which a busy write and config
  // scramble are injected; abort_at: cycle at which reset is asserted mid-frame.
  task automatic send_frame(input logic [7:0] d, input logic e, input logic p,
                            input logic o, input logic [15:0] div,
                            input logic [10:0] exp_f, input int intr_at,
                            input int abort_at);
    int dd;
    dd = (div == 16'd0) ? 1 : int'(div);
    check("pre_load_txrdy", txrdy, 1'b1);
    din = d; eight = e; pen = p; ohel = o; baud_div = div; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    for (int i = 0; i < 11 * dd; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_txrdy", txrdy, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (i == intr_at) begin
        din = 8'hFF; load = 1'b1;
        baud_div = 16'($urandom_range(0, 9));
        eight = ~e; pen = ~p; ohel = ~o;
      end
      check("frame_tx", tx, exp_f[i / dd]);
      check("frame_txrdy", txrdy, 1'b0);
      @(posedge clk); #1;
      load = 1'b0;
    end
    check("post_txrdy", txrdy, 1'b1);
    check("post_tx", tx, 1'b1);
  endtask

  initial begin
    logic [7:0]  rd;
    logic        re, rp, ro;
    logic [15:0] rdiv;

    reset = 1'b1; load = 1'b0; din = 8'h00; baud_div = 16'd4;
    eight = 1'b0; pen = 1'b0; ohel = 1'b0;
    @(posedge clk); #1;
    check("rst_tx", tx, 1'b1);
    check("rst_txrdy", txrdy, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    idle_cycles(2);

    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 16'd4, 11'b11010101010, -1, -1);
    idle_cycles(2);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0, 16'd2, 11'b10000000110, -1, -1);
    idle_cycles(1);
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 16'd2, 11'b11000000010, -1, -1);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 16'd2, 11'b11000000010, -1, -1);
    idle_cycles(1);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 16'd3, 11'b11101001010, 10, -1);
    idle_cycles(4);

    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 16'd5, 11'b11000011110, -1, 22);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 16'd5, 11'b11000011110, -1, -1);
    idle_cycles(1);

    send_frame(8'h80, 1'b1, 1'b0, 1'b0, 16'd0, 11'b11100000000, -1, -1);
    send_frame(8'h80, 1'b1, 1'b0, 1'b0, 16'd0, 11'b11100000000, -1, -1);
    idle_cycles(2);

    for (int k = 0; k < 16; k++) begin
      rd   = 8'($urandom);
      re   = 1'($urandom);
      rp   = 1'($urandom);
      ro   = 1'($urandom);
      rdiv = 16'($urandom_range(0, 6));
      send_frame(rd, re, rp, ro, rdiv, ref_frame(rd, re, rp, ro),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1, -1);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    rd = 8'($urandom);
    send_frame(rd, 1'b1, 1'b1, 1'b1, 16'hFFFF, ref_frame(rd, 1'b1, 1'b1, 1'b1), -1, 65540);
    rd = 8'($urandom);
    send_frame(rd, 1'b0, 1'b1, 1'b0, 16'd3, ref_frame(rd, 1'b0, 1'b1, 1'b0), -1, -1);
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
